// File: rtl/cfa_pkg.sv
// Shared constants and types for the 5x5 Bayer window producer.
// Consumers of the window can use cfa_window_t for the default pixel width.
package cfa_pkg;

   localparam int CFA_PIX_W = 12;
   localparam int WIN       = 5;
   localparam int HALF      = 2;
   localparam int N_LB      = 4;

   typedef logic [CFA_PIX_W-1:0] cfa_window_t [0:WIN-1][0:WIN-1];

endpackage

// File: rtl/cfa_line_buffer.sv
// Single-port, read-first synchronous line buffer.
// One access per enabled cycle: dout returns the old word, din optionally replaces it.
module cfa_line_buffer #(
   parameter int DEPTH = 64,
   parameter int WIDTH = 12,
   parameter int AW    = 6
) (
   input  logic             clk,
   input  logic             en,
   input  logic             we,
   input  logic [AW-1:0]    addr,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout
);

   logic [WIDTH-1:0] r_mem [0:DEPTH-1];

   // NOTE: storage arrays carry no reset so they map onto RAM macros; every
   // word is rewritten with fresh rows before a window can ever read it.
   always_ff @(posedge clk) begin
      if (en) begin
         dout <= r_mem[addr];
         if (we) begin
            r_mem[addr] <= din;
         end
      end
   end

endmodule

// File: rtl/cfa_window_5x5.sv
// Raster stream to 5x5 Bayer neighbourhood: four line buffers, a 5x5 shift
// window and registered outputs, one start pulse per interior pixel.
module cfa_window_5x5
   import cfa_pkg::*;
#(
   parameter int PIX_W = CFA_PIX_W,
   parameter int IMG_W = 64,
   parameter int IMG_H = 64,
   parameter int CNT_W = 11
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [PIX_W-1:0] pix_in,
   input  logic             pix_valid,
   input  logic             pix_sof,
   output logic [PIX_W-1:0] p_m2_m2, p_m2_m1, p_m2_p0, p_m2_p1, p_m2_p2,
   output logic [PIX_W-1:0] p_m1_m2, p_m1_m1, p_m1_p0, p_m1_p1, p_m1_p2,
   output logic [PIX_W-1:0] p_p0_m2, p_p0_m1, p_p0_p0, p_p0_p1, p_p0_p2,
   output logic [PIX_W-1:0] p_p1_m2, p_p1_m1, p_p1_p0, p_p1_p1, p_p1_p2,
   output logic [PIX_W-1:0] p_p2_m2, p_p2_m1, p_p2_p0, p_p2_p1, p_p2_p2,
   output logic             start,
   output logic [CNT_W-1:0] ctr_row,
   output logic [CNT_W-1:0] ctr_col,
   output logic             frame_done
);

   localparam int AW = (IMG_W > 1) ? $clog2(IMG_W) : 1;

   typedef logic [PIX_W-1:0] win_t [0:WIN-1][0:WIN-1];

   logic [CNT_W-1:0] r_row, r_col;
   logic [CNT_W-1:0] w_row, w_col;

   // NOTE: always_comb assigns every output up front, so no path can infer a latch.
   always_comb begin
      w_row = r_row;
      w_col = r_col;
      if (pix_sof) begin
         w_row = '0;
         w_col = '0;
      end
   end

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples the pre-edge values of its neighbours.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_row <= '0;
         r_col <= '0;
      end else if (pix_valid) begin
         if (w_col == CNT_W'(IMG_W-1)) begin
            r_col <= '0;
            r_row <= (w_row == CNT_W'(IMG_H-1)) ? '0 : w_row + CNT_W'(1);
         end else begin
            r_col <= w_col + CNT_W'(1);
            r_row <= w_row;
         end
      end
   end

   // Row r is written to bank r mod 4; the bank being overwritten still hands
   // back row r-4 (read-first), the other three return rows r-1..r-3.
   logic [PIX_W-1:0] w_lb_dout [0:N_LB-1];

   for (genvar b = 0; b < N_LB; b++) begin : g_lb
      cfa_line_buffer #(
         .DEPTH (IMG_W),
         .WIDTH (PIX_W),
         .AW    (AW)
      ) u_lb (
         .clk  (clk),
         .en   (pix_valid),
         .we   (pix_valid && (w_row[1:0] == 2'(b))),
         .addr (w_col[AW-1:0]),
         .din  (pix_in),
         .dout (w_lb_dout[b])
      );
   end

   logic             r_s1_valid;
   logic [PIX_W-1:0] r_s1_pix;
   logic [CNT_W-1:0] r_s1_row, r_s1_col;

   always_ff @(posedge clk) begin
      if (rst) r_s1_valid <= 1'b0;
      else     r_s1_valid <= pix_valid;
   end

   always_ff @(posedge clk) begin
      if (pix_valid) begin
         r_s1_pix <= pix_in;
         r_s1_row <= w_row;
         r_s1_col <= w_col;
      end
   end

   logic [PIX_W-1:0] w_newcol [0:WIN-1];

   always_comb begin
      for (int i = 0; i < N_LB; i++) begin
         w_newcol[i] = w_lb_dout[2'(r_s1_row[1:0] + 2'(i))];
      end
      w_newcol[WIN-1] = r_s1_pix;
   end

   win_t             r_win;
   logic             r_s2_start, r_s2_last;
   logic [CNT_W-1:0] r_s2_row, r_s2_col;

   always_ff @(posedge clk) begin
      if (r_s1_valid) begin
         for (int i = 0; i < WIN; i++) begin
            for (int j = 0; j < WIN-1; j++) begin
               r_win[i][j] <= r_win[i][j+1];
            end
            r_win[i][WIN-1] <= w_newcol[i];
         end
         r_s2_row  <= r_s1_row - CNT_W'(HALF);
         r_s2_col  <= r_s1_col - CNT_W'(HALF);
         r_s2_last <= (r_s1_row == CNT_W'(IMG_H-1)) && (r_s1_col == CNT_W'(IMG_W-1));
      end
   end

   always_ff @(posedge clk) begin
      if (rst) r_s2_start <= 1'b0;
      else     r_s2_start <= r_s1_valid && (r_s1_row >= CNT_W'(WIN-1))
                                        && (r_s1_col >= CNT_W'(WIN-1));
   end

   win_t             r_p;
   logic             r_start, r_frame_done;
   logic [CNT_W-1:0] r_ctr_row, r_ctr_col;

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < WIN; i++) begin
            for (int j = 0; j < WIN; j++) begin
               r_p[i][j] <= '0;
            end
         end
         r_start      <= 1'b0;
         r_frame_done <= 1'b0;
         r_ctr_row    <= '0;
         r_ctr_col    <= '0;
      end else begin
         r_start      <= r_s2_start;
         r_frame_done <= r_s2_start && r_s2_last;
         if (r_s2_start) begin
            r_p       <= r_win;
            r_ctr_row <= r_s2_row;
            r_ctr_col <= r_s2_col;
         end
      end
   end

   assign start      = r_start;
   assign frame_done = r_frame_done;
   assign ctr_row    = r_ctr_row;
   assign ctr_col    = r_ctr_col;

   assign p_m2_m2 = r_p[0][0];
   assign p_m2_m1 = r_p[0][1];
   assign p_m2_p0 = r_p[0][2];
   assign p_m2_p1 = r_p[0][3];
   assign p_m2_p2 = r_p[0][4];
   assign p_m1_m2 = r_p[1][0];
   assign p_m1_m1 = r_p[1][1];
   assign p_m1_p0 = r_p[1][2];
   assign p_m1_p1 = r_p[1][3];
   assign p_m1_p2 = r_p[1][4];
   assign p_p0_m2 = r_p[2][0];
   assign p_p0_m1 = r_p[2][1];
   assign p_p0_p0 = r_p[2][2];
   assign p_p0_p1 = r_p[2][3];
   assign p_p0_p2 = r_p[2][4];
   assign p_p1_m2 = r_p[3][0];
   assign p_p1_m1 = r_p[3][1];
   assign p_p1_p0 = r_p[3][2];
   assign p_p1_p1 = r_p[3][3];
   assign p_p1_p2 = r_p[3][4];
   assign p_p2_m2 = r_p[4][0];
   assign p_p2_m1 = r_p[4][1];
   assign p_p2_p0 = r_p[4][2];
   assign p_p2_p1 = r_p[4][3];
   assign p_p2_p2 = r_p[4][4];

endmodule

// File: tb/tb_cfa_window_5x5.sv
// Bench for cfa_window_5x5 on an 8x8 image: a frame-image model predicts each
// window, its output edge and frame_done; outputs are compared every cycle.
module tb_cfa_window_5x5;

   localparam int PW = 12;
   localparam int W  = 8;
   localparam int H  = 8;
   localparam int CW = 11;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          pix_valid = 1'b0;
   logic          pix_sof = 1'b0;
   logic [PW-1:0] pix_in = '0;

   wire [PW-1:0]  p [0:4][0:4];
   wire           start, frame_done;
   wire [CW-1:0]  ctr_row, ctr_col;

   always #5 clk = ~clk;

   cfa_window_5x5 #(.PIX_W(PW), .IMG_W(W), .IMG_H(H), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst), .pix_in(pix_in), .pix_valid(pix_valid), .pix_sof(pix_sof),
      .p_m2_m2(p[0][0]), .p_m2_m1(p[0][1]), .p_m2_p0(p[0][2]), .p_m2_p1(p[0][3]), .p_m2_p2(p[0][4]),
      .p_m1_m2(p[1][0]), .p_m1_m1(p[1][1]), .p_m1_p0(p[1][2]), .p_m1_p1(p[1][3]), .p_m1_p2(p[1][4]),
      .p_p0_m2(p[2][0]), .p_p0_m1(p[2][1]), .p_p0_p0(p[2][2]), .p_p0_p1(p[2][3]), .p_p0_p2(p[2][4]),
      .p_p1_m2(p[3][0]), .p_p1_m1(p[3][1]), .p_p1_p0(p[3][2]), .p_p1_p1(p[3][3]), .p_p1_p2(p[3][4]),
      .p_p2_m2(p[4][0]), .p_p2_m1(p[4][1]), .p_p2_p0(p[4][2]), .p_p2_p1(p[4][3]), .p_p2_p2(p[4][4]),
      .start(start), .ctr_row(ctr_row), .ctr_col(ctr_col), .frame_done(frame_done)
   );

   typedef struct {
      int           due;
      int           cr;
      int           cc;
      logic [319:0] win;
      logic         fd;
   } exp_t;

   exp_t         q[$];
   int           img [0:H-1][0:W-1];
   int           mrow = 0, mcol = 0, cyc = 0;
   int           n_checks = 0, n_pass = 0;
   int           n_starts = 0, n_exp_starts = 0, n_fd = 0;
   logic [319:0] last_win = '0;
   int           last_r = 0, last_c = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [319:0] got, input logic [319:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, got, exp);
   endtask

   function automatic logic [319:0] dut_win();
      logic [319:0] v = '0;
      for (int a = 0; a < 5; a++)
         for (int b = 0; b < 5; b++)
            v[(a*5+b)*PW +: PW] = p[a][b];
      return v;
   endfunction

   // Compare everything visible after the most recent rising edge.
   task automatic observe();
      exp_t e;
      logic exp_start;
      logic exp_fd;
      exp_start = (q.size() > 0) && (q[0].due == cyc);
      exp_fd    = 1'b0;
      if (exp_start) begin
         e        = q.pop_front();
         last_win = e.win;
         last_r   = e.cr;
         last_c   = e.cc;
         exp_fd   = e.fd;
      end
      check("start", 320'(start), 320'(exp_start));
      check("frame_done", 320'(frame_done), 320'(exp_fd));
      check("window", dut_win(), last_win);
      check("ctr_row", 320'(ctr_row), 320'(last_r));
      check("ctr_col", 320'(ctr_col), 320'(last_c));
      if (start) n_starts++;
      if (frame_done) n_fd++;
   endtask

   // One clock: check outputs, drive the next edge's inputs, update the model.
   task automatic tick(input logic v, input logic s, input logic r, input logic pat);
      int           rr, cc;
      logic [PW-1:0] px;
      exp_t         e;
      @(negedge clk);
      observe();
      rr = s ? 0 : mrow;
      cc = s ? 0 : mcol;
      px = pat ? PW'(16*rr + cc) : PW'($urandom);
      rst       = r;
      pix_valid = v;
      pix_sof   = s;
      pix_in    = px;
      if (r) begin
         n_exp_starts -= q.size();
         q.delete();
         mrow = 0; mcol = 0;
         last_win = '0; last_r = 0; last_c = 0;
      end else if (v) begin
         img[rr][cc] = int'(px);
         if (rr >= 4 && cc >= 4) begin
            e.due = cyc + 3;
            e.cr  = rr - 2;
            e.cc  = cc - 2;
            e.fd  = (rr == H-1) && (cc == W-1);
            e.win = '0;
            for (int a = 0; a < 5; a++)
               for (int b = 0; b < 5; b++)
                  e.win[(a*5+b)*PW +: PW] = PW'(img[rr-4+a][cc-4+b]);
            q.push_back(e);
            n_exp_starts++;
         end
         if (cc == W-1) begin
            mcol = 0;
            mrow = (rr == H-1) ? 0 : rr + 1;
         end else begin
            mcol = cc + 1;
            mrow = rr;
         end
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      tick(1'b0, 1'b0, 1'b1, 1'b0);
      tick(1'b0, 1'b0, 1'b1, 1'b0);
      idle(2);

      // Pattern frame, continuous, with sof on the first pixel.
      for (int i = 0; i < W*H; i++) tick(1'b1, i == 0, 1'b0, 1'b1);
      idle(4);
      check("starts_frame1", 320'(n_starts), 320'(16));
      check("fd_frame1", 320'(n_fd), 320'(1));

      // Back-to-back frame relying on counter wrap only.
      for (int i = 0; i < W*H; i++) tick(1'b1, 1'b0, 1'b0, 1'b1);
      idle(4);
      check("starts_frame2", 320'(n_starts), 320'(32));

      // Same image with valid pattern 1,0,0,...
      for (int i = 0; i < W*H; i++) begin
         tick(1'b1, 1'b0, 1'b0, 1'b1);
         idle(2);
      end
      idle(4);
      check("starts_stall", 320'(n_starts), 320'(48));
      check("fd_stall", 320'(n_fd), 320'(3));

      // Random pixels, random gaps, three frames.
      for (int i = 0; i < 3*W*H; i++) begin
         tick(1'b1, i == 0, 1'b0, 1'b0);
         if ($urandom_range(3) == 0) idle($urandom_range(1, 3));
      end
      idle(4);
      check("starts_random", 320'(n_starts), 320'(n_exp_starts));

      // Resync: sof arrives on the 21st pixel of a frame.
      for (int i = 0; i < 20; i++) tick(1'b1, i == 0, 1'b0, 1'b0);
      for (int i = 0; i < W*H; i++) tick(1'b1, i == 0, 1'b0, 1'b0);
      idle(4);
      check("starts_resync", 320'(n_starts), 320'(n_exp_starts));

      // Reset during row 5 (pix_valid high on the reset edge), then no sof.
      for (int i = 0; i < 44; i++) tick(1'b1, i == 0, 1'b0, 1'b0);
      tick(1'b1, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < W*H; i++) tick(1'b1, 1'b0, 1'b0, 1'b0);
      idle(4);
      check("starts_reset", 320'(n_starts), 320'(n_exp_starts));
      check("queue_drained", 320'(q.size()), 320'(0));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
